// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: owns the PC, the instruction memory and the IF/ID
// pipeline register. Memory is loaded while IDLE; RUN fetches one word per
// cycle, honouring decode stalls and jump/branch redirects. A HALT word
// (all ones) stops fetching until reset.
module instruction_fetch_stage #(
   parameter int NBITS     = 32,
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_W    = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_hazard_detected,
   input  logic              i_redirect,
   input  logic [NBITS-1:0]  i_redirect_addr,
   input  logic              i_load_en,
   input  logic [ADDR_W-1:0] i_load_addr,
   input  logic [NBITS-1:0]  i_load_data,
   input  logic              i_run,
   output logic [NBITS-1:0]  o_pc,
   output logic [NBITS-1:0]  o_instruction,
   output logic              o_valid,
   output logic              o_halted
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   localparam logic [NBITS-1:0] HALT_WORD = {NBITS{1'b1}};
   localparam logic [NBITS-1:0] NOP_WORD  = {NBITS{1'b0}};
   localparam logic [NBITS-1:0] PC_STEP   = {{(NBITS-3){1'b0}}, 3'b100};
   localparam logic [NBITS-1:0] ALIGN_MSK = ~{{(NBITS-2){1'b0}}, 2'b11};

   // Registers
   state_t            r_state;
   logic [NBITS-1:0]  r_pc;
   logic [NBITS-1:0]  r_ifid_pc;
   logic [NBITS-1:0]  r_ifid_instr;
   logic              r_valid;
   logic              r_halted;
   logic [NBITS-1:0]  r_mem [MEM_DEPTH];

   // Next-state wires
   state_t            w_state_next;
   logic [NBITS-1:0]  w_pc_next;
   logic [NBITS-1:0]  w_ifid_pc_next;
   logic [NBITS-1:0]  w_ifid_instr_next;
   logic              w_valid_next;
   logic              w_halted_next;
   logic              w_mem_we;

   // Datapath helpers
   logic [NBITS-1:0]  w_fetch_word;
   logic [NBITS-1:0]  w_pc_plus4;
   logic [NBITS-1:0]  w_redirect_pc;

   // The index ignores the upper PC bits, so fetch wraps every MEM_DEPTH words.
   assign w_fetch_word  = r_mem[r_pc[ADDR_W+1:2]];
   assign w_pc_plus4    = r_pc + PC_STEP;
   assign w_redirect_pc = i_redirect_addr & ALIGN_MSK;

   // Instruction memory write port; contents deliberately survive reset.
   always_ff @(posedge i_clk) begin
      if (w_mem_we) begin
         r_mem[i_load_addr] <= i_load_data;
      end
   end

   // State, PC and IF/ID register update with asynchronous active-low reset.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state      <= ST_IDLE;
         r_pc         <= NOP_WORD;
         r_ifid_pc    <= NOP_WORD;
         r_ifid_instr <= NOP_WORD;
         r_valid      <= 1'b0;
         r_halted     <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_pc         <= w_pc_next;
         r_ifid_pc    <= w_ifid_pc_next;
         r_ifid_instr <= w_ifid_instr_next;
         r_valid      <= w_valid_next;
         r_halted     <= w_halted_next;
      end
   end

   // Next-state and IF/ID decision: redirect beats stall beats HALT beats fetch.
   always_comb begin
      w_state_next      = r_state;
      w_pc_next         = r_pc;
      w_ifid_pc_next    = r_ifid_pc;
      w_ifid_instr_next = r_ifid_instr;
      w_valid_next      = r_valid;
      w_halted_next     = r_halted;
      w_mem_we          = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_mem_we          = i_load_en;
            w_pc_next         = NOP_WORD;
            w_ifid_pc_next    = NOP_WORD;
            w_ifid_instr_next = NOP_WORD;
            w_valid_next      = 1'b0;
            w_halted_next     = 1'b0;
            if (i_run) begin
               w_state_next = ST_RUN;
            end else begin
               w_state_next = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (i_redirect) begin
               w_pc_next         = w_redirect_pc;
               w_ifid_pc_next    = NOP_WORD;
               w_ifid_instr_next = NOP_WORD;
               w_valid_next      = 1'b0;
            end else if (i_hazard_detected) begin
               w_pc_next         = r_pc;
            end else if (w_fetch_word == HALT_WORD) begin
               // o_pc keeps the last fetched PC+4; only the instruction flushes.
               w_ifid_instr_next = NOP_WORD;
               w_valid_next      = 1'b0;
               w_halted_next     = 1'b1;
               w_state_next      = ST_HALT;
            end else begin
               w_ifid_instr_next = w_fetch_word;
               w_ifid_pc_next    = w_pc_plus4;
               w_valid_next      = 1'b1;
               w_pc_next         = w_pc_plus4;
            end
         end
         ST_HALT: begin
            w_ifid_instr_next = NOP_WORD;
            w_valid_next      = 1'b0;
            w_halted_next     = 1'b1;
            w_state_next      = ST_HALT;
         end
         default: begin
            w_state_next      = ST_IDLE;
            w_pc_next         = NOP_WORD;
            w_ifid_pc_next    = NOP_WORD;
            w_ifid_instr_next = NOP_WORD;
            w_valid_next      = 1'b0;
            w_halted_next     = 1'b0;
         end
      endcase
   end

   assign o_pc          = r_ifid_pc;
   assign o_instruction = r_ifid_instr;
   assign o_valid       = r_valid;
   assign o_halted      = r_halted;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Table-driven bench for instruction_fetch_stage: load, fetch, stall,
// redirect (including over a HALT word), index wrap, ignored inputs,
// halt behaviour and asynchronous reset.
module tb_instruction_fetch_stage;

   logic        i_clk;
   logic        i_rst;
   logic        i_hazard_detected;
   logic        i_redirect;
   logic [31:0] i_redirect_addr;
   logic        i_load_en;
   logic [7:0]  i_load_addr;
   logic [31:0] i_load_data;
   logic        i_run;
   logic [31:0] o_pc;
   logic [31:0] o_instruction;
   logic        o_valid;
   logic        o_halted;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        haz;
      logic        redir;
      logic [31:0] raddr;
      logic        ld;
      logic [7:0]  laddr;
      logic [31:0] ldata;
      logic        run;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
      logic        e_valid;
      logic        e_halted;
      logic        chk_pc;
   } vec_t;

   vec_t tab_a[$];
   vec_t tab_b[$];

   instruction_fetch_stage #(.NBITS(32), .MEM_DEPTH(256), .ADDR_W(8)) dut (
      .i_clk             (i_clk),
      .i_rst             (i_rst),
      .i_hazard_detected (i_hazard_detected),
      .i_redirect        (i_redirect),
      .i_redirect_addr   (i_redirect_addr),
      .i_load_en         (i_load_en),
      .i_load_addr       (i_load_addr),
      .i_load_data       (i_load_data),
      .i_run             (i_run),
      .o_pc              (o_pc),
      .o_instruction     (o_instruction),
      .o_valid           (o_valid),
      .o_halted          (o_halted)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(input logic haz, input logic redir, input logic [31:0] raddr,
                               input logic ld, input logic [7:0] laddr, input logic [31:0] ldata,
                               input logic run, input logic [31:0] e_pc, input logic [31:0] e_instr,
                               input logic e_valid, input logic e_halted, input logic chk_pc);
      vec_t v;
      v.haz = haz; v.redir = redir; v.raddr = raddr;
      v.ld = ld; v.laddr = laddr; v.ldata = ldata; v.run = run;
      v.e_pc = e_pc; v.e_instr = e_instr; v.e_valid = e_valid;
      v.e_halted = e_halted; v.chk_pc = chk_pc;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input int idx, input logic [31:0] e_pc,
                             input logic [31:0] e_instr, input logic e_valid,
                             input logic e_halted, input logic chk_pc);
      if (chk_pc) chk({tag, ".o_pc"}, idx, o_pc, e_pc);
      chk({tag, ".o_instruction"}, idx, o_instruction, e_instr);
      chk({tag, ".o_valid"}, idx, {31'd0, o_valid}, {31'd0, e_valid});
      chk({tag, ".o_halted"}, idx, {31'd0, o_halted}, {31'd0, e_halted});
   endtask

   task automatic idle_inputs();
      i_hazard_detected = 1'b0;
      i_redirect        = 1'b0;
      i_redirect_addr   = 32'd0;
      i_load_en         = 1'b0;
      i_load_addr       = 8'd0;
      i_load_data       = 32'd0;
      i_run             = 1'b0;
   endtask

   // Drive one vector after a falling edge, let one rising edge pass, check at the next falling edge.
   task automatic apply(input string tag, input int idx, input vec_t v);
      i_hazard_detected = v.haz;
      i_redirect        = v.redir;
      i_redirect_addr   = v.raddr;
      i_load_en         = v.ld;
      i_load_addr       = v.laddr;
      i_load_data       = v.ldata;
      i_run             = v.run;
      @(posedge i_clk);
      @(negedge i_clk);
      check_outs(tag, idx, v.e_pc, v.e_instr, v.e_valid, v.e_halted, v.chk_pc);
   endtask

   initial begin
      // Phase A: load a three-word program ending in HALT, run it, check halt.
      //                  haz   redir raddr   ld    laddr ldata         run   e_pc   e_instr       v     h     chkpc
      tab_a.push_back(mk(1'b0, 1'b0, 32'd0, 1'b1, 8'd0, 32'h2001_0005, 1'b0, 32'd0, 32'h0,        1'b0, 1'b0, 1'b1));
      tab_a.push_back(mk(1'b0, 1'b0, 32'd0, 1'b1, 8'd1, 32'h2002_0003, 1'b0, 32'd0, 32'h0,        1'b0, 1'b0, 1'b1));
      tab_a.push_back(mk(1'b0, 1'b1, 32'h40, 1'b1, 8'd2, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h0,       1'b0, 1'b0, 1'b1));
      tab_a.push_back(mk(1'b0, 1'b0, 32'd0, 1'b0, 8'd0, 32'h0,         1'b1, 32'd0, 32'h0,        1'b0, 1'b0, 1'b1));
      tab_a.push_back(mk(1'b0, 1'b0, 32'd0, 1'b0, 8'd0, 32'h0,         1'b0, 32'd4, 32'h2001_0005, 1'b1, 1'b0, 1'b1));
      tab_a.push_back(mk(1'b0, 1'b0, 32'd0, 1'b0, 8'd0, 32'h0,         1'b0, 32'd8, 32'h2002_0003, 1'b1, 1'b0, 1'b1));
      tab_a.push_back(mk(1'b0, 1'b0, 32'd0, 1'b0, 8'd0, 32'h0,         1'b0, 32'd0, 32'h0,        1'b0, 1'b1, 1'b0));
      tab_a.push_back(mk(1'b1, 1'b1, 32'h18, 1'b1, 8'd0, 32'h1234_5678, 1'b1, 32'd0, 32'h0,       1'b0, 1'b1, 1'b0));

      // Phase B: extend the program, stall, redirect over HALT words, wrap the index.
      tab_b.push_back(mk(1'b0, 1'b0, 32'd0, 1'b1, 8'd2,   32'h2222_2222, 1'b0, 32'd0, 32'h0,    1'b0, 1'b0, 1'b1));
      tab_b.push_back(mk(1'b0, 1'b0, 32'd0, 1'b1, 8'd3,   32'hFFFF_FFFF, 1'b0, 32'd0, 32'h0,    1'b0, 1'b0, 1'b1));
      tab_b.push_back(mk(1'b0, 1'b0, 32'd0, 1'b1, 8'd6,   32'h6666_6666, 1'b0, 32'd0, 32'h0,    1'b0, 1'b0, 1'b1));
      tab_b.push_back(mk(1'b0, 1'b0, 32'd0, 1'b1, 8'd7,   32'hFFFF_FFFF, 1'b0, 32'd0, 32'h0,    1'b0, 1'b0, 1'b1));
      tab_b.push_back(mk(1'b0, 1'b0, 32'd0, 1'b1, 8'd255, 32'hABCD_0123, 1'b0, 32'd0, 32'h0,    1'b0, 1'b0, 1'b1));
      tab_b.push_back(mk(1'b0, 1'b0, 32'd0, 1'b1, 8'd5,   32'h5555_5555, 1'b1, 32'd0, 32'h0,    1'b0, 1'b0, 1'b1));
      tab_b.push_back(mk(1'b0, 1'b0, 32'd0, 1'b0, 8'd0, 32'h0, 1'b0, 32'd4,  32'h2001_0005, 1'b1, 1'b0, 1'b1));
      tab_b.push_back(mk(1'b0, 1'b0, 32'd0, 1'b0, 8'd0, 32'h0, 1'b0, 32'd8,  32'h2002_0003, 1'b1, 1'b0, 1'b1));
      tab_b.push_back(mk(1'b1, 1'b0, 32'd0, 1'b0, 8'd0, 32'h0, 1'b0, 32'd8,  32'h2002_0003, 1'b1, 1'b0, 1'b1));
      tab_b.push_back(mk(1'b1, 1'b0, 32'd0, 1'b0, 8'd0, 32'h0, 1'b0, 32'd8,  32'h2002_0003, 1'b1, 1'b0, 1'b1));
      tab_b.push_back(mk(1'b1, 1'b0, 32'd0, 1'b0, 8'd0, 32'h0, 1'b0, 32'd8,  32'h2002_0003, 1'b1, 1'b0, 1'b1));
      tab_b.push_back(mk(1'b0, 1'b0, 32'd0, 1'b0, 8'd0, 32'h0, 1'b0, 32'd12, 32'h2222_2222, 1'b1, 1'b0, 1'b1));
      // PC now points at the HALT word (word 3); redirect with a stall must win.
      tab_b.push_back(mk(1'b1, 1'b1, 32'h0000_001B, 1'b0, 8'd0, 32'h0, 1'b0, 32'd0, 32'h0, 1'b0, 1'b0, 1'b1));
      tab_b.push_back(mk(1'b0, 1'b0, 32'd0, 1'b0, 8'd0, 32'h0, 1'b0, 32'h1C, 32'h6666_6666, 1'b1, 1'b0, 1'b1));
      // PC points at word 7 (HALT); redirect to word 255 while a load is attempted.
      tab_b.push_back(mk(1'b0, 1'b1, 32'h0000_03FC, 1'b1, 8'd0, 32'hDEAD_BEEF, 1'b0, 32'd0, 32'h0, 1'b0, 1'b0, 1'b1));
      tab_b.push_back(mk(1'b0, 1'b0, 32'd0, 1'b1, 8'd1, 32'hBADB_AD00, 1'b1, 32'h400, 32'hABCD_0123, 1'b1, 1'b0, 1'b1));
      tab_b.push_back(mk(1'b0, 1'b0, 32'd0, 1'b0, 8'd0, 32'h0, 1'b0, 32'h404, 32'h2001_0005, 1'b1, 1'b0, 1'b1));
      tab_b.push_back(mk(1'b0, 1'b0, 32'd0, 1'b0, 8'd0, 32'h0, 1'b0, 32'h408, 32'h2002_0003, 1'b1, 1'b0, 1'b1));
      tab_b.push_back(mk(1'b0, 1'b0, 32'd0, 1'b0, 8'd0, 32'h0, 1'b0, 32'h40C, 32'h2222_2222, 1'b1, 1'b0, 1'b1));
      tab_b.push_back(mk(1'b0, 1'b0, 32'd0, 1'b0, 8'd0, 32'h0, 1'b0, 32'd0,   32'h0,         1'b0, 1'b1, 1'b0));
      tab_b.push_back(mk(1'b0, 1'b1, 32'h0000_0018, 1'b0, 8'd0, 32'h0, 1'b1, 32'd0, 32'h0,   1'b0, 1'b1, 1'b0));

      // Reset state
      idle_inputs();
      i_rst = 1'b0;
      @(negedge i_clk);
      @(negedge i_clk);
      check_outs("reset", 0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      i_rst = 1'b1;

      foreach (tab_a[i]) apply("progA", i, tab_a[i]);

      // Asynchronous reset while halted
      idle_inputs();
      #2 i_rst = 1'b0;
      #1 check_outs("rst_halt", 0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      #1 i_rst = 1'b1;
      @(negedge i_clk);

      // Restart from address 0 with memory intact, then reset mid-RUN
      apply("rerun", 0, mk(1'b0, 1'b0, 32'd0, 1'b0, 8'd0, 32'h0, 1'b1, 32'd0, 32'h0, 1'b0, 1'b0, 1'b1));
      apply("rerun", 1, mk(1'b0, 1'b0, 32'd0, 1'b0, 8'd0, 32'h0, 1'b0, 32'd4, 32'h2001_0005, 1'b1, 1'b0, 1'b1));
      apply("rerun", 2, mk(1'b0, 1'b0, 32'd0, 1'b0, 8'd0, 32'h0, 1'b0, 32'd8, 32'h2002_0003, 1'b1, 1'b0, 1'b1));
      idle_inputs();
      #2 i_rst = 1'b0;
      #1 check_outs("rst_run", 0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      #1 i_rst = 1'b1;
      @(negedge i_clk);
      check_outs("rst_run", 1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);

      foreach (tab_b[i]) apply("progB", i, tab_b[i]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- Producer end of the fetch-to-decode interface: owns the PC, the instruction memory and the IF/ID pipeline register.
- Drives the decode stage's PC and instruction inputs.
- Obeys the decode-side hazard stall and the jump/branch redirect.
- Memory is filled through a load port before execution starts; a HALT word stops fetching.

Parameters:
- NBITS, 32, datapath/PC/instruction width.
- MEM_DEPTH, 256, instruction memory depth in words.
- ADDR_W, 8, word index width (log2 MEM_DEPTH).

Ports:
- i_clk  in  1  single clock; all state on rising edge.
- i_rst  in  1  asynchronous, active-low reset (0 = reset).
- i_hazard_detected  in  1  stall request from decode.
- i_redirect  in  1  taken jump/branch; PC must be replaced.
- i_redirect_addr  in  NBITS  redirect target byte address.
- i_load_en  in  1  memory write strobe (IDLE only).
- i_load_addr  in  ADDR_W  word index to write.
- i_load_data  in  NBITS  word to write.
- i_run  in  1  start execution (IDLE only).
- o_pc  out  NBITS  PC+4 of the instruction held in IF/ID.
- o_instruction  out  NBITS  instruction held in IF/ID.
- o_valid  out  1  IF/ID holds a real fetched instruction.
- o_halted  out  1  HALT word reached; fetching stopped.

Behaviour:
- Reset (async, i_rst=0):
  - PC=0, o_pc=0, o_instruction=0x00000000 (NOP), o_valid=0, o_halted=0, state=IDLE.
  - Memory contents are not cleared.
- States: IDLE, RUN, HALT.
- IDLE:
  - i_load_en=1 writes mem[i_load_addr]<=i_load_data on the clock edge.
  - IF/ID holds NOP with o_valid=0.
  - i_run=1 moves to RUN on the next edge; PC stays 0.
  - i_run together with i_load_en: the write completes and the state still moves to RUN.
  - i_redirect and i_hazard_detected are ignored.
- RUN, evaluated each cycle in priority order:
  1. i_redirect=1: PC<=i_redirect_addr with bits[1:0] forced to 0. IF/ID<=NOP, o_pc<=0, o_valid<=0 (flush). Redirect wins over stall and over a HALT word at the current PC.
  2. i_hazard_detected=1: PC, o_pc, o_instruction and o_valid all hold.
  3. Fetched word mem[PC[ADDR_W+1:2]]==0xFFFFFFFF: IF/ID<=NOP, o_valid<=0, PC holds, state<=HALT, o_halted<=1 on the same edge.
  4. Otherwise: o_instruction<=mem[PC[ADDR_W+1:2]], o_pc<=PC+4, o_valid<=1, PC<=PC+4.
- Memory read is combinational from the PC register. Fetch latency is one cycle: the instruction at PC appears on o_instruction after the next edge.
- The first instruction reaches IF/ID 2 edges after the i_run edge (1 for IDLE->RUN, 1 for fetch).
- PC+4 wraps modulo 2^NBITS.
- The memory index uses PC[ADDR_W+1:2] only, so it wraps at MEM_DEPTH words; upper PC bits do not affect the index.
- In RUN and HALT, i_load_en and i_run are ignored.
- HALT:
  - IF/ID=NOP, o_valid=0, o_halted=1, PC frozen.
  - All inputs are ignored; only reset leaves HALT.
- Reset asserted mid-RUN or in HALT returns everything to reset values immediately (asynchronously). Memory is retained, so i_run alone restarts the program from address 0.

Test Plan:
- Load 0x20010005@0, 0x20020003@1, 0xFFFFFFFF@2, then pulse i_run. Expect:
  - o_instruction=0x20010005/o_pc=4/o_valid=1.
  - Then 0x20020003/o_pc=8.
  - Then o_valid=0, o_halted=1, PC held at 8.
- Reset behaviour: assert i_rst=0 asynchronously mid-RUN, between clock edges. Expect all outputs at reset values before the next edge. After release, pulse i_run: the program re-executes from 0 with memory intact.
- Stall: hold i_hazard_detected=1 for 3 cycles while 0x20020003 (o_pc=8) is in IF/ID. Expect the outputs unchanged for 3 cycles, then the next word with o_pc=12.
- Redirect: i_redirect=1 with i_redirect_addr=0x0000001B and i_hazard_detected=1 in the same cycle. Expect:
  - NOP with o_valid=0 on that edge.
  - Next fetch from word 6 with o_pc=0x1C.
- Redirect vs HALT: redirect asserted while PC points at the HALT word. Expect no halt (o_halted=0) and fetch to continue at the target.
- Wrap and ignored inputs: redirect to 0x000003FC (word 255). Expect the fetch of word 255 with o_pc=0x400, then a fetch of word 0 (index wrap). i_load_en pulses during RUN leave memory unchanged.
